truth_table_scanner: RTL and testbench

Sequencer that exhaustively drives an N-input combinational network (default 4 inputs, single output z) through all 2^N input codes. It samples z after a fixed settle time and assembles the measured truth table, counting its minterms and comparing it against an expected table. It sits beside any single-output combinational network in the design and is the standard harness for on-chip check of Karnaugh-minimised networks.

---
 rtl/truth_table_scanner_pkg.sv | 28 ++
 rtl/truth_table_scanner_if.sv | 38 +++
 rtl/truth_table_scanner_settle_timer.sv | 40 ++++
 rtl/truth_table_scanner.sv | 112 +++++++++++
 tb/tb_truth_table_scanner.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/truth_table_scanner_pkg.sv
// =====================================================================
// truth_table_scanner_pkg : shared state type and width helpers
// Rev 1.0
// =====================================================================
`default_nettype none

package truth_table_scanner_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int DEF_N_IN = 4;

    // Table holds one bit per input code; the ones count must reach 2^N_IN.
    function automatic int table_w(input int n_in);
        return 1 << n_in;
    endfunction

    function automatic int cnt_w(input int n_in);
        return n_in + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/truth_table_scanner_if.sv
// =====================================================================
// truth_table_scanner_if : request, network and result signals
// Rev 1.0
// =====================================================================
`default_nettype none

interface truth_table_scanner_if
    import truth_table_scanner_pkg::*;
#(
    parameter int N_IN = DEF_N_IN
);
    localparam int TABLE_W = table_w(N_IN);
    localparam int CNT_W   = cnt_w(N_IN);

    logic               start_i;
    logic [TABLE_W-1:0] expected_i;
    logic               z_i;
    logic [N_IN-1:0]    x_o;
    logic               busy_o;
    logic               done_o;
    logic [TABLE_W-1:0] table_o;
    logic [CNT_W-1:0]   ones_o;
    logic               mismatch_o;
    logic [N_IN-1:0]    first_err_o;

    modport slave (
        input  start_i, expected_i, z_i,
        output x_o, busy_o, done_o, table_o, ones_o, mismatch_o, first_err_o
    );

    modport master (
        output start_i, expected_i, z_i,
        input  x_o, busy_o, done_o, table_o, ones_o, mismatch_o, first_err_o
    );

endinterface

`default_nettype wire

// File: rtl/truth_table_scanner_settle_timer.sv
// =====================================================================
// truth_table_scanner_settle_timer : wrapping 0..SETTLE-1 hold counter
// Rev 1.0
// =====================================================================
`default_nettype none

module truth_table_scanner_settle_timer #(
    parameter int SETTLE = 2
) (
    input  wire logic clock_i,
    input  wire logic reset_i,
    input  wire logic clear_i,
    output logic      tc_o
);
    localparam int         W    = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [W-1:0] LAST = W'(SETTLE - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign tc_o = !clear_i && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clear_i || tc_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/truth_table_scanner.sv
// =====================================================================
// truth_table_scanner : drives all 2^N_IN codes, records and checks z
// Rev 1.0
// =====================================================================
`default_nettype none

module truth_table_scanner
    import truth_table_scanner_pkg::*;
#(
    parameter int N_IN   = DEF_N_IN,
    parameter int SETTLE = 2
) (
    input  wire logic            clock_i,
    input  wire logic            reset_i,
    truth_table_scanner_if.slave bus
);
    localparam int              TABLE_W  = table_w(N_IN);
    localparam int              CNT_W    = cnt_w(N_IN);
    localparam logic [N_IN-1:0] LAST_IDX = N_IN'(TABLE_W - 1);

    state_t             state_q;
    logic [N_IN-1:0]    index_q;
    logic [N_IN-1:0]    index_d;
    logic [TABLE_W-1:0] exp_q;
    logic [TABLE_W-1:0] table_q;
    logic [CNT_W-1:0]   ones_q;
    logic               mismatch_q;
    logic [N_IN-1:0]    first_err_q;
    logic               busy_q;
    logic               done_q;
    logic               settle_tc;
    logic               z_mis;

    truth_table_scanner_settle_timer #(
        .SETTLE (SETTLE)
    ) u_settle (
        .clock_i (clock_i),
        .reset_i (reset_i),
        .clear_i (state_q != ST_SCAN),
        .tc_o    (settle_tc)
    );

    assign index_d = index_q + 1'b1;
    assign z_mis   = bus.z_i ^ exp_q[index_q];

    // x is the index register itself; it is parked at 0 outside a scan.
    assign bus.x_o         = index_q;
    assign bus.busy_o      = busy_q;
    assign bus.done_o      = done_q;
    assign bus.table_o     = table_q;
    assign bus.ones_o      = ones_q;
    assign bus.mismatch_o  = mismatch_q;
    assign bus.first_err_o = first_err_q;

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= ST_IDLE;
            index_q     <= '0;
            exp_q       <= '0;
            table_q     <= '0;
            ones_q      <= '0;
            mismatch_q  <= 1'b0;
            first_err_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start_i) begin
                        exp_q       <= bus.expected_i;
                        table_q     <= '0;
                        ones_q      <= '0;
                        mismatch_q  <= 1'b0;
                        first_err_q <= '0;
                        index_q     <= '0;
                        busy_q      <= 1'b1;
                        state_q     <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (settle_tc) begin
                        table_q[index_q] <= bus.z_i;
                        ones_q           <= ones_q + CNT_W'(bus.z_i);
                        if (z_mis && !mismatch_q) begin
                            mismatch_q  <= 1'b1;
                            first_err_q <= index_q;
                        end
                        if (index_q == LAST_IDX) begin
                            index_q <= '0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= ST_DONE;
                        end else begin
                            index_q <= index_d;
                        end
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_truth_table_scanner.sv
// =====================================================================
// tb_truth_table_scanner : two scanners (SETTLE=2 and SETTLE=1) on a
// table-driven network, checked against a truth-table reference model
// Rev 1.1
// =====================================================================
`default_nettype none

module tb_truth_table_scanner;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        sel;
    logic [15:0] net_tbl;
    logic [15:0] expected;
    int          n_chk  = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    truth_table_scanner_if #(.N_IN(4)) ba ();
    truth_table_scanner_if #(.N_IN(4)) bb ();

    assign ba.start_i    = start & ~sel;
    assign bb.start_i    = start & sel;
    assign ba.expected_i = expected;
    assign bb.expected_i = expected;
    assign ba.z_i        = net_tbl[ba.x_o];
    assign bb.z_i        = net_tbl[bb.x_o];

    truth_table_scanner #(.N_IN(4), .SETTLE(2)) u_dut_a (
        .clock_i (clk),
        .reset_i (rst),
        .bus     (ba.slave)
    );

    truth_table_scanner #(.N_IN(4), .SETTLE(1)) u_dut_b (
        .clock_i (clk),
        .reset_i (rst),
        .bus     (bb.slave)
    );

    wire [3:0]  obs_x    = sel ? bb.x_o         : ba.x_o;
    wire        obs_busy = sel ? bb.busy_o      : ba.busy_o;
    wire        obs_done = sel ? bb.done_o      : ba.done_o;
    wire [15:0] obs_tbl  = sel ? bb.table_o     : ba.table_o;
    wire [4:0]  obs_ones = sel ? bb.ones_o      : ba.ones_o;
    wire        obs_mis  = sel ? bb.mismatch_o  : ba.mismatch_o;
    wire [3:0]  obs_fe   = sel ? bb.first_err_o : ba.first_err_o;

    function automatic int popc(input logic [15:0] v);
        int n = 0;
        for (int i = 0; i < 16; i++) n += int'(v[i]);
        return n;
    endfunction

    function automatic int first_diff(input logic [15:0] a, input logic [15:0] b);
        for (int i = 0; i < 16; i++) if (a[i] != b[i]) return i;
        return 0;
    endfunction

    task automatic fail(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_fail++;
        $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        $error("check %s", tag);
    endtask

    task automatic check_zero();
        n_chk++; if (obs_x    !== 4'd0)  fail("rst_x",    obs_x,    4'd0);
        n_chk++; if (obs_busy !== 1'b0)  fail("rst_busy", obs_busy, 1'b0);
        n_chk++; if (obs_done !== 1'b0)  fail("rst_done", obs_done, 1'b0);
        n_chk++; if (obs_tbl  !== 16'h0) fail("rst_tbl",  obs_tbl,  16'h0);
        n_chk++; if (obs_ones !== 5'd0)  fail("rst_ones", obs_ones, 5'd0);
        n_chk++; if (obs_mis  !== 1'b0)  fail("rst_mis",  obs_mis,  1'b0);
        n_chk++; if (obs_fe   !== 4'd0)  fail("rst_fe",   obs_fe,   4'd0);
    endtask

    // One full scan; the model's table is simply the network table,
    // since every code is held long enough for z to settle.
    task automatic run_scan(input logic [15:0] net, input logic [15:0] ex, input bit chg);
        int          k;
        int          xbad;
        int          dbad;
        int          settle;
        logic [15:0] cap;
        logic        exp_mis;
        logic [3:0]  exp_fe;
        logic [4:0]  exp_ones;
        settle   = sel ? 1 : 2;
        net_tbl  = net;
        expected = ex;
        cap      = ex;
        exp_mis  = (net != cap);
        exp_fe   = 4'(first_diff(net, cap));
        exp_ones = 5'(popc(net));
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 0; xbad = 0; dbad = 0;
        while (obs_busy === 1'b1 && k < 200) begin
            if (obs_x !== 4'(k / settle)) xbad++;
            if (obs_done !== 1'b0) dbad++;
            if (chg) expected = 16'($urandom);
            k++;
            @(negedge clk);
        end
        n_chk++; if (k        !== 16 * settle) fail("busy_cycles", k, 16 * settle);
        n_chk++; if (xbad     !== 0)           fail("x_sequence",  xbad, 0);
        n_chk++; if (dbad     !== 0)           fail("done_early",  dbad, 0);
        n_chk++; if (obs_done !== 1'b1)        fail("done_pulse",  obs_done, 1'b1);
        n_chk++; if (obs_x    !== 4'd0)        fail("x_done",      obs_x, 4'd0);
        n_chk++; if (obs_tbl  !== net)         fail("table",       obs_tbl, net);
        n_chk++; if (obs_ones !== exp_ones)    fail("ones",        obs_ones, exp_ones);
        n_chk++; if (obs_mis  !== exp_mis)     fail("mismatch",    obs_mis, exp_mis);
        n_chk++; if (obs_fe   !== exp_fe)      fail("first_err",   obs_fe, exp_fe);
        @(negedge clk);
        n_chk++; if (obs_done !== 1'b0)        fail("done_width",  obs_done, 1'b0);
        n_chk++; if (obs_tbl  !== net)         fail("table_hold",  obs_tbl, net);
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (obs_done !== 1'b1 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        n_chk++; if (cyc >= 100) fail("done_seen", cyc, 100);
    endtask

    initial begin
        int          c;
        int          t;
        int          bcnt;
        logic [15:0] n;
        logic [15:0] e;

        rst = 1'b1; start = 1'b0; sel = 1'b0; net_tbl = '0; expected = '0;
        repeat (3) @(negedge clk);
        check_zero();
        sel = 1'b1;
        check_zero();
        sel = 1'b0;
        rst = 1'b0;
        @(negedge clk);

        run_scan(16'hECF0, 16'hECF0, 1'b0);
        run_scan(16'hECF0, 16'hECF1, 1'b0);
        run_scan(16'hECF0, 16'hEDF0, 1'b0);

        for (int i = 0; i < 6; i++) begin
            n = 16'($urandom);
            if (i == 0)      e = n;
            else if (i % 2) e = n ^ (16'h1 << $urandom_range(15, 0));
            else             e = 16'($urandom);
            run_scan(n, e, (i >= 3));
        end

        net_tbl = 16'hFFFF; expected = 16'h0000; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        #2 rst = 1'b1;
        #1 check_zero();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_scan(16'($urandom), 16'($urandom), 1'b0);

        net_tbl = 16'h5A3C; expected = 16'h5A3C; start = 1'b1;
        wait_done(c);
        t = 0; bcnt = 0;
        do begin
            @(negedge clk);
            t++;
            if (obs_busy === 1'b1) bcnt++;
        end while (obs_done !== 1'b1 && t < 100);
        n_chk++; if (t        !== 34)                  fail("b2b_interval", t, 34);
        n_chk++; if (bcnt     !== 32)                  fail("b2b_busy",     bcnt, 32);
        n_chk++; if (obs_tbl  !== 16'h5A3C)            fail("b2b_table",    obs_tbl, 16'h5A3C);
        n_chk++; if (obs_ones !== 5'(popc(16'h5A3C)))  fail("b2b_ones",     obs_ones, 5'(popc(16'h5A3C)));
        n_chk++; if (obs_mis  !== 1'b0)                fail("b2b_mis",      obs_mis, 1'b0);
        start = 1'b0;
        repeat (2) @(negedge clk);
        n_chk++; if (obs_busy !== 1'b0)                fail("b2b_stop",     obs_busy, 1'b0);

        sel = 1'b1;
        @(negedge clk);
        run_scan(16'hFFFF, 16'hFFFF, 1'b0);
        run_scan(16'h0000, 16'h0000, 1'b0);
        run_scan(16'($urandom), 16'($urandom), 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, observed timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
